// File: rtl/rv32i_mem_arbiter.sv
// Shares one synchronous memory port between the multicycle RV32I core and a debug/loader
// requester; debug has priority but is capped at MAX_BURST consecutive cycles.
module rv32i_mem_arbiter #(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wr_data,
   input  logic        core_wr_ena,
   output logic [31:0] core_rd_data,
   output logic        core_ena,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wr_data,
   input  logic        dbg_wr_ena,
   output logic        dbg_gnt,
   output logic        dbg_rd_valid,
   output logic [31:0] dbg_rd_data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   output logic        mem_wr_ena,
   input  logic [31:0] mem_rd_data
);

   localparam logic [7:0] MaxBurst = MAX_BURST[7:0];

   logic [7:0]  burst_q, burst_d;
   logic        prev_core_q, prev_core_d;
   logic        prev_dbg_rd_q, prev_dbg_rd_d;
   logic [31:0] core_hold_q, core_hold_d;

   // Grant is purely combinational so debug sees ownership in the same cycle it asks.
   always_comb begin
      dbg_gnt  = rst & dbg_req & (burst_q < MaxBurst);
      core_ena = rst & ena & ~dbg_gnt;
   end

   always_comb begin
      if (dbg_gnt) begin
         mem_addr    = dbg_addr;
         mem_wr_data = dbg_wr_data;
         mem_wr_ena  = dbg_wr_ena;
      end else begin
         mem_addr    = core_addr;
         mem_wr_data = core_wr_data;
         mem_wr_ena  = core_wr_ena & core_ena;
      end
   end

   always_comb begin
      burst_d       = dbg_gnt ? burst_q + 8'd1 : 8'd0;
      prev_core_d   = core_ena;
      prev_dbg_rd_d = dbg_gnt & ~dbg_wr_ena;
      core_hold_d   = prev_core_q ? mem_rd_data : core_hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_q       <= 8'd0;
         prev_core_q   <= 1'b0;
         prev_dbg_rd_q <= 1'b0;
         core_hold_q   <= 32'd0;
      end else begin
         burst_q       <= burst_d;
         prev_core_q   <= prev_core_d;
         prev_dbg_rd_q <= prev_dbg_rd_d;
         core_hold_q   <= core_hold_d;
      end
   end

   // Core keeps seeing its last enabled read while frozen.
   always_comb begin
      core_rd_data = prev_core_q ? mem_rd_data : core_hold_q;
      dbg_rd_valid = prev_dbg_rd_q;
      dbg_rd_data  = mem_rd_data;
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter with MAX_BURST=4 and a one-cycle-latency memory.
module tb_rv32i_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        ena;
   logic [31:0] core_addr;
   logic [31:0] core_wr_data;
   logic        core_wr_ena;
   logic [31:0] core_rd_data;
   logic        core_ena;
   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wr_data;
   logic        dbg_wr_ena;
   logic        dbg_gnt;
   logic        dbg_rd_valid;
   logic [31:0] dbg_rd_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_ena;
   logic [31:0] mem_rd_data;

   rv32i_mem_arbiter #(.MAX_BURST(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .core_addr    (core_addr),
      .core_wr_data (core_wr_data),
      .core_wr_ena  (core_wr_ena),
      .core_rd_data (core_rd_data),
      .core_ena     (core_ena),
      .dbg_req      (dbg_req),
      .dbg_addr     (dbg_addr),
      .dbg_wr_data  (dbg_wr_data),
      .dbg_wr_ena   (dbg_wr_ena),
      .dbg_gnt      (dbg_gnt),
      .dbg_rd_valid (dbg_rd_valid),
      .dbg_rd_data  (dbg_rd_data),
      .mem_addr     (mem_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ena   (mem_wr_ena),
      .mem_rd_data  (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];

   always @(posedge clk) begin
      if (mem_wr_ena) mem[mem_addr[9:2]] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr[9:2]];
   end

   typedef struct packed {
      logic        gnt;
      logic        cena;
      logic        dvld;
      logic        chk_crd;
      logic [31:0] crd;
      logic [31:0] maddr;
   } cyc_exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_exp_t;

   cyc_exp_t    cyc_q[$];
   logic [31:0] dbg_q[$];
   wr_exp_t     wr_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: per-cycle control expectations plus valid-driven read and write scoreboards.
   always @(negedge clk) begin
      cyc_exp_t e;
      wr_exp_t  w;
      logic [31:0] d;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e.gnt});
         chk("core_ena", {31'd0, core_ena}, {31'd0, e.cena});
         chk("dbg_rd_valid", {31'd0, dbg_rd_valid}, {31'd0, e.dvld});
         chk("mem_addr", mem_addr, e.maddr);
         if (e.chk_crd) chk("core_rd_data", core_rd_data, e.crd);
      end
      if (dbg_rd_valid) begin
         if (dbg_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dbg_read_unexpected: got valid with data %h, expected none", dbg_rd_data);
         end else begin
            d = dbg_q.pop_front();
            chk("dbg_rd_data", dbg_rd_data, d);
         end
      end
      if (mem_wr_ena) begin
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mem_write_unexpected: got %h @ %h, expected no write", mem_wr_data,
                     mem_addr);
         end else begin
            w = wr_q.pop_front();
            chk("mem_wr_addr", mem_addr, w.addr);
            chk("mem_wr_data", mem_wr_data, w.data);
         end
      end
   end

   task automatic step(input logic g, input logic c, input logic v, input logic ck,
                       input logic [31:0] crd);
      cyc_exp_t e;
      e.gnt     = g;
      e.cena    = c;
      e.dvld    = v;
      e.chk_crd = ck;
      e.crd     = crd;
      e.maddr   = g ? dbg_addr : core_addr;
      cyc_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10 >> 2] = 32'hDEADBEEF;
      mem[8'h20 >> 2] = 32'h12345678;
      mem[8'h30 >> 2] = 32'h33333333;
      mem[8'h34 >> 2] = 32'h34343434;
      mem[8'h38 >> 2] = 32'h38383838;
      mem[8'h80 >> 2] = 32'hCAFE0080;
      mem[8'h84 >> 2] = 32'h0BAD0084;
      mem_rd_data  = 32'h0;
      rst          = 1'b1;
      ena          = 1'b0;
      core_addr    = 32'h0;
      core_wr_data = 32'h0;
      core_wr_ena  = 1'b0;
      dbg_req      = 1'b0;
      dbg_addr     = 32'h0;
      dbg_wr_data  = 32'h0;
      dbg_wr_ena   = 1'b0;
      @(posedge clk);
      #1;

      // Reset with every request active: nothing granted or written.
      rst          = 1'b0;
      ena          = 1'b1;
      dbg_req      = 1'b1;
      dbg_wr_ena   = 1'b1;
      dbg_addr     = 32'h60;
      core_wr_ena  = 1'b1;
      core_addr    = 32'h64;
      core_wr_data = 32'h1111;
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      rst         = 1'b1;
      ena         = 1'b0;
      dbg_req     = 1'b0;
      dbg_wr_ena  = 1'b0;
      core_wr_ena = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Idle: core reads 0x10 for 10 cycles.
      ena       = 1'b1;
      core_addr = 32'h10;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, (i == 0) ? 32'h0 : 32'hDEADBEEF);

      // Burst limit: gnt pattern 1111 0 1111 0 11.
      dbg_req  = 1'b1;
      dbg_addr = 32'h30;
      for (int i = 0; i < 12; i++) begin
         logic g;
         g = (i != 4) && (i != 9);
         if (g) dbg_q.push_back(32'h33333333);
         step(g, !g, !((i == 0) || (i == 5) || (i == 10)), 1'b1, 32'hDEADBEEF);
      end

      // Stall hold: core reads 0x20, then three debug reads freeze it.
      dbg_req   = 1'b0;
      core_addr = 32'h20;
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
      dbg_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dbg_addr = 32'h30 + 32'(4 * i);
         dbg_q.push_back((i == 0) ? 32'h33333333 : (i == 1) ? 32'h34343434 : 32'h38383838);
         step(1'b1, 1'b0, (i != 0), 1'b1, 32'h12345678);
      end
      dbg_req = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678);

      // Write conflict: debug write lands first, core store follows.
      dbg_req      = 1'b1;
      dbg_wr_ena   = 1'b1;
      dbg_addr     = 32'h40;
      dbg_wr_data  = 32'h5555;
      core_wr_ena  = 1'b1;
      core_addr    = 32'h40;
      core_wr_data = 32'hAAAA;
      wr_q.push_back('{addr: 32'h40, data: 32'h5555});
      wr_q.push_back('{addr: 32'h40, data: 32'hAAAA});
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      dbg_req    = 1'b0;
      dbg_wr_ena = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      core_wr_ena = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      core_addr = 32'h10;
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000AAAA);

      // Debug read routing: debug reads 0x80, core reads 0x84 next cycle.
      dbg_req   = 1'b1;
      dbg_addr  = 32'h80;
      core_addr = 32'h84;
      dbg_q.push_back(32'hCAFE0080);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      dbg_req = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD0084);

      // Reset mid-burst: second burst cycle is killed, no write escapes.
      dbg_req     = 1'b1;
      dbg_wr_ena  = 1'b1;
      dbg_addr    = 32'h50;
      dbg_wr_data = 32'h50505050;
      wr_q.push_back('{addr: 32'h50, data: 32'h50505050});
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      rst         = 1'b0;
      core_wr_ena = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      rst         = 1'b1;
      core_wr_ena = 1'b0;
      dbg_wr_ena  = 1'b0;
      dbg_addr    = 32'h30;
      for (int i = 0; i < 5; i++) begin
         logic g;
         g = (i < 4);
         if (g) dbg_q.push_back(32'h33333333);
         step(g, !g, (i > 0), 1'b0, 32'h0);
      end
      dbg_req = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

      chk("dbg_reads_drained", 32'(dbg_q.size()), 32'd0);
      chk("writes_drained", 32'(wr_q.size()), 32'd0);
      chk("mem_0x40_final", mem[8'h40 >> 2], 32'h0000AAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Cycle-level arbiter that shares the single synchronous memory port between the multicycle RV32I core and a debug/loader requester. It drives the core's `ena` so the core freezes on any cycle it does not own the memory. It routes one-cycle-latency read data back to whichever requester issued the read, and holds the core's read data across stalls. It sits between `rv32i_multicycle_core` and the memory model in the top level.

## Interface
Parameters:
- `MAX_BURST`, default 8: maximum consecutive debug-owned cycles before one core cycle is forced; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  system enable for the core side; debug arbitration is independent of it.
- `core_addr`  in  32  core memory address (core `mem_addr`).
- `core_wr_data`  in  32  core store data.
- `core_wr_ena`  in  1  core store strobe.
- `core_rd_data`  out  32  read data to core `mem_rd_data`.
- `core_ena`  out  1  enable to core `ena`.
- `dbg_req`  in  1  debug requests the port this cycle.
- `dbg_addr`  in  32  debug address.
- `dbg_wr_data`  in  32  debug store data.
- `dbg_wr_ena`  in  1  debug store strobe; `0` means read.
- `dbg_gnt`  out  1  debug owns the port this cycle.
- `dbg_rd_valid`  out  1  `dbg_rd_data` carries data for the previous cycle's granted debug read.
- `dbg_rd_data`  out  32  debug read data.
- `mem_addr`  out  32  to memory.
- `mem_wr_data`  out  32  to memory.
- `mem_wr_ena`  out  1  to memory.
- `mem_rd_data`  in  32  from memory; valid one cycle after its address.

## Operation
- **Owner each cycle** is DEBUG if `dbg_gnt`, else CORE.
  - `dbg_gnt = rst & dbg_req & (burst_cnt < MAX_BURST)`.
  - `core_ena = rst & ena & ~dbg_gnt`.
- **`burst_cnt`** is 8 bits, reset 0.
  - Increments on each edge where `dbg_gnt=1`.
  - Cleared on each edge where `dbg_gnt=0`.
  - Never exceeds `MAX_BURST`.
  - Reaching `MAX_BURST` forces exactly one non-debug cycle. On that cycle `core_ena=ena`, the counter clears, and debug may win again on the next cycle.
- **Memory mux** (combinational):
  - If `dbg_gnt`: `mem_addr=dbg_addr`, `mem_wr_data=dbg_wr_data`, `mem_wr_ena=dbg_wr_ena`.
  - Else: `mem_addr=core_addr`, `mem_wr_data=core_wr_data`, `mem_wr_ena=core_wr_ena & core_ena`.
  - While `rst=0`, `mem_wr_ena=0`.
- **Read tracking registers** (all reset 0):
  - `prev_core <= core_ena`.
  - `prev_dbg_rd <= dbg_gnt & ~dbg_wr_ena`.
  - `core_hold <= mem_rd_data` when `prev_core=1`; otherwise it holds.
- **Read outputs:**
  - `core_rd_data = prev_core ? mem_rd_data : core_hold`. This means the core sees data for its last enabled access until its next enabled cycle.
  - `dbg_rd_valid = prev_dbg_rd`.
  - `dbg_rd_data = mem_rd_data`.
- **Core with `ena=0`:** it never writes, `prev_core` clears, and `core_hold` is retained.
- **Simultaneous debug write and core store:** debug wins, and the core store is deferred because the core stays frozen.

## Timing
- **Grant:** zero-latency combinational grant; `dbg_gnt` depends only on `dbg_req`, `burst_cnt` and `rst`.
- **Debug read:** address in cycle N gives `dbg_rd_valid=1` and data in N+1, independent of the owner in N+1.
- **Core stall:** a core read in N followed by k stall cycles gives identical `core_rd_data` in N+1 through N+1+k.
- **Reset values:**
  - `dbg_gnt=0`, `core_ena=0`, `mem_wr_ena=0`, `dbg_rd_valid=0`.
  - `core_rd_data=0`.
  - `mem_addr=core_addr` and `mem_wr_data=core_wr_data` (pass-through).
- **Reset asserted mid-burst:** counter and trackers clear immediately, and no write reaches memory while reset is low.
- **Reset release:** the first edge after release arbitrates normally, with `burst_cnt=0`.

## Test plan
All scenarios use `MAX_BURST=4`.
- **Idle:** `dbg_req=0`, `ena=1` for 10 cycles, core reads `0x10`, memory returns `0xDEADBEEF` → `core_ena=1` every cycle; `core_rd_data=0xDEADBEEF` one cycle after the address.
- **Burst limit:** `dbg_req` held high for 12 cycles → `dbg_gnt` pattern `1111 0 1111 0 11`; `core_ena=1` exactly on the two `0` cycles.
- **Stall hold:** core reads `0x20` (data `0x12345678`) in cycle N, then `dbg_req=1` for 3 cycles while memory returns other values → `core_rd_data=0x12345678` in N+1..N+4.
- **Write conflict:** core stores `0xAAAA` to `0x40` while debug writes `0x5555` to `0x40` → first write to reach memory is `0x5555` with `mem_wr_ena` on debug's cycle; core store reaches memory on the first non-debug cycle, final value `0xAAAA`.
- **Debug read routing:** debug reads `0x80`, then core reads `0x84` in the next cycle → `dbg_rd_valid=1` with `0x80` data in cycle N+1 only; `core_rd_data` shows `0x84` data in N+2.
- **Reset mid-burst:** `rst` low at burst cycle 2 → all outputs at reset values within the same cycle and no `mem_wr_ena`; after release, debug receives a full 4-cycle burst.
